// File: rtl/alu_div_pkg.sv
// rtl/alu_div_pkg.sv - shared types and helpers for the sequential DIV/REM unit
//
// Purpose: FSM state encoding, the fill bit used to build the divide-by-zero
// quotient, and a one-bit cell for conditional two's-complement negation.
// The cell is chained LSB-first by the user, so it works for any operand width.
package alu_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Every quotient bit takes this value on a divide by zero (all ones).
    localparam logic DIVZERO_FILL = 1'b1;

    // One bit of (neg ? ~v + 1 : v). Start the chain with carry_in = 1.
    // Returns {carry_out, result_bit}.
    function automatic logic [1:0] cneg_bit(input logic b, input logic neg, input logic carry_in);
        logic [1:0] res;
        if (neg) begin
            res = {~b & carry_in, ~b ^ carry_in};
        end else begin
            res = {1'b0, b};
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Purpose: shift the next dividend bit into the partial remainder, compare
// against the divisor magnitude on N+1 bits and subtract when it fits.
// Ports:
//   partial_in  [N-1:0]  partial remainder from the previous step (< divisor_mag)
//   divisor_mag [N-1:0]  divisor magnitude (non-zero)
//   bit_in               next dividend bit, MSB first
//   partial_out [N-1:0]  new partial remainder
//   qbit                 quotient bit produced by this step
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] partial_in,
    input  logic [N-1:0] divisor_mag,
    input  logic         bit_in,
    output logic [N-1:0] partial_out,
    output logic         qbit
);

    logic [N:0]   shifted;
    logic [N-1:0] diff;

    assign shifted = {partial_in, bit_in};
    // A set top bit means the shifted value is >= 2^N and therefore above any divisor.
    assign qbit    = shifted[N] | (shifted[N-1:0] >= divisor_mag);
    // The true difference is below the divisor, so the N-bit wrapped result is exact.
    assign diff    = shifted[N-1:0] - divisor_mag;
    assign partial_out = qbit ? diff : shifted[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative radix-2 restoring DIV/REM unit with handshakes
//
// Purpose: N-cycle signed/unsigned divider; one div_step reused per cycle.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operation handshake (in_ready high only when idle)
//   dividend, divisor [N]   operands, sampled only on the accepting edge
//   signed_mode             1 = two's-complement operands (when SIGNED_EN)
//   out_valid / out_ready   result handshake (out_valid high only when done)
//   quotient, remainder [N] result
//   div_zero                divisor was zero for this result
module seq_divider
    import alu_div_pkg::*;
#(
    parameter int N         = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         signed_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    localparam int CNT_W = $clog2(N);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     part;     // partial remainder
    logic [N-1:0]     dvd;      // dividend bits shift out at the top, quotient bits in at the bottom
    logic [N-1:0]     dmag;
    logic             neg_q;
    logic             neg_r;
    logic             dz_pend;  // divide by zero: one pass through BUSY, no iterations

    logic             sm;
    logic             a_neg;
    logic             b_neg;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [N-1:0]     step_part;
    logic             step_q;
    logic [N-1:0]     q_next;
    logic [N-1:0]     q_fix;
    logic [N-1:0]     r_fix;

    function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic neg);
        logic [N-1:0] r;
        logic         c;
        logic [1:0]   rc;
        c = 1'b1;
        r = '0;
        for (int i = 0; i < N; i++) begin
            rc   = cneg_bit(v[i], neg, c);
            r[i] = rc[0];
            c    = rc[1];
        end
        return r;
    endfunction

    assign sm    = SIGNED_EN & signed_mode;
    assign a_neg = sm & dividend[N-1];
    assign b_neg = sm & divisor[N-1];
    assign a_mag = mag(dividend, a_neg);
    assign b_mag = mag(divisor, b_neg);

    div_step #(.N(N)) u_step (
        .partial_in  (part),
        .divisor_mag (dmag),
        .bit_in      (dvd[N-1]),
        .partial_out (step_part),
        .qbit        (step_q)
    );

    assign q_next = {dvd[N-2:0], step_q};
    // Most-negative / -1 yields magnitude 2^(N-1) with positive sign, which
    // reads back as most-negative: the overflow rule falls out naturally.
    assign q_fix  = mag(q_next, neg_q);
    assign r_fix  = mag(step_part, neg_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            part      <= '0;
            dvd       <= '0;
            dmag      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_pend   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                        part     <= '0;
                        dmag     <= b_mag;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        if (divisor == '0) begin
                            dvd     <= dividend;
                            cnt     <= '0;
                            dz_pend <= 1'b1;
                        end else begin
                            dvd     <= a_mag;
                            cnt     <= CNT_W'(N - 1);
                            dz_pend <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    part <= step_part;
                    dvd  <= q_next;
                    if (cnt == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        if (dz_pend) begin
                            quotient  <= {N{DIVZERO_FILL}};
                            remainder <= dvd;
                            div_zero  <= 1'b1;
                        end else begin
                            quotient  <= q_fix;
                            remainder <= r_fix;
                            div_zero  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
